// File: rtl/controlador_passos_m.sv
// Step controller: pulses soma/sub on a saturating position counter until pos reaches the latched target.
// Optional abort input enabled by defining CONTROLADOR_ABORTA_EN.
module controlador_passos_m #(
  parameter int unsigned M       = 100,
  parameter int unsigned N       = 7,
  parameter int unsigned T_PASSO = 50000,
  parameter int unsigned W_T     = 16
) (
  input  logic         clock,
  input  logic         zera_s,
  input  logic         inicia,
`ifdef CONTROLADOR_ABORTA_EN
  input  logic         aborta,
`endif
  input  logic [N-1:0] alvo,
  input  logic [N-1:0] pos,
  output logic         soma,
  output logic         sub,
  output logic         ocupado,
  output logic         pronto,
  output logic [2:0]   db_estado
);

  localparam logic [N-1:0]   ALVO_MAX = N'(M - 1);
  localparam logic [W_T-1:0] TICK_FIM = W_T'(T_PASSO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    COMPARA = 3'd1,
    ESPERA  = 3'd2,
    PASSO   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t        estado;
  logic [N-1:0]   alvo_reg;
  logic [W_T-1:0] tick;

  assign db_estado = estado;

  // Pulse outputs default low every cycle; each transition raises the one it needs.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado   <= OCIOSO;
      alvo_reg <= '0;
      tick     <= '0;
      soma     <= 1'b0;
      sub      <= 1'b0;
      pronto   <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      soma   <= 1'b0;
      sub    <= 1'b0;
      pronto <= 1'b0;
`ifdef CONTROLADOR_ABORTA_EN
      if (aborta && (estado != OCIOSO)) begin
        estado  <= OCIOSO;
        ocupado <= 1'b0;
      end else
`endif
      begin
        case (estado)
          OCIOSO: begin
            if (inicia) begin
              alvo_reg <= (alvo > ALVO_MAX) ? ALVO_MAX : alvo;
              estado   <= COMPARA;
              ocupado  <= 1'b1;
            end
          end
          COMPARA: begin
            if (pos == alvo_reg) begin
              estado <= FIM;
              pronto <= 1'b1;
            end else begin
              tick   <= '0;
              estado <= ESPERA;
            end
          end
          ESPERA: begin
            if (tick == TICK_FIM) begin
              estado <= PASSO;
              // Out-of-range pos compares above any legal target, so it steps down.
              if (pos < alvo_reg) soma <= 1'b1;
              else                sub  <= 1'b1;
            end else begin
              tick <= tick + W_T'(1);
            end
          end
          PASSO: estado <= COMPARA;
          FIM: begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
          default: begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controlador_passos_m.sv
// Randomized bench for controlador_passos_m with a saturating counter model driven by soma/sub.
module tb_controlador_passos_m;

  localparam int unsigned M       = 100;
  localparam int unsigned N       = 7;
  localparam int unsigned T_PASSO = 4;
  localparam int unsigned W_T     = 16;
  localparam int          PER     = T_PASSO + 2;

  logic         clock = 1'b0;
  logic         zera_s;
  logic         inicia;
  logic [N-1:0] alvo;
  logic [N-1:0] pos;
  logic         soma;
  logic         sub;
  logic         ocupado;
  logic         pronto;
  logic [2:0]   db_estado;
`ifdef CONTROLADOR_ABORTA_EN
  logic         aborta;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  controlador_passos_m #(
    .M(M), .N(N), .T_PASSO(T_PASSO), .W_T(W_T)
  ) dut (
    .clock    (clock),
    .zera_s   (zera_s),
    .inicia   (inicia),
`ifdef CONTROLADOR_ABORTA_EN
    .aborta   (aborta),
`endif
    .alvo     (alvo),
    .pos      (pos),
    .soma     (soma),
    .sub      (sub),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock; the modelled counter applies the pulse seen during the cycle just ended.
  task automatic tick();
    logic s;
    logic b;
    s = soma;
    b = sub;
    @(posedge clock);
    #1;
    if (s === 1'b1 && pos < N'(M - 1)) pos = pos + N'(1);
    else if (b === 1'b1 && pos > 0)    pos = pos - N'(1);
  endtask

  // Move from p0 toward a; expected pulses land every PER cycles, pronto two cycles after the last one.
  task automatic run_move(input int p0, input int a, input bit poke);
    int t;
    int k;
    int last;
    bit up;
    bit step;
    pos    = N'(p0);
    alvo   = N'(a);
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
    alvo   = N'($urandom_range(0, 127));
    t    = (a > int'(M) - 1) ? int'(M) - 1 : a;
    up   = (t > p0);
    k    = up ? (t - p0) : (p0 - t);
    last = PER * k + 2;
    for (int n = 1; n <= last + 1; n++) begin
      step = ((n % PER) == 0) && (n <= PER * k);
      check_eq("soma", 32'(soma), 32'(step && up));
      check_eq("sub", 32'(sub), 32'(step && !up));
      check_eq("pronto", 32'(pronto), 32'(n == last));
      check_eq("ocupado", 32'(ocupado), 32'(n <= last));
      if (n == 1) check_eq("db_estado_compara", 32'(db_estado), 32'd1);
      if (poke && n == 3) begin
        inicia = 1'b1;
        alvo   = N'(50);
      end else begin
        inicia = 1'b0;
      end
      tick();
    end
    check_eq("pos_final", 32'(pos), 32'(t));
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_eq({tag, "_soma"}, 32'(soma), 32'd0);
      check_eq({tag, "_sub"}, 32'(sub), 32'd0);
      check_eq({tag, "_pronto"}, 32'(pronto), 32'd0);
      check_eq({tag, "_ocupado"}, 32'(ocupado), 32'd0);
      tick();
    end
  endtask

  task automatic reset_mid_move();
    pos    = N'(10);
    alvo   = N'(30);
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
    repeat (3) tick();
    check_eq("rst_pre_estado", 32'(db_estado), 32'd2);
    zera_s = 1'b1;
    tick();
    zera_s = 1'b0;
    check_eq("rst_db_estado", 32'(db_estado), 32'd0);
    check_quiet("rst", 3 * PER);
    check_eq("rst_pos_hold", 32'(pos), 32'd10);
  endtask

`ifdef CONTROLADOR_ABORTA_EN
  task automatic abort_mid_move();
    pos    = N'(60);
    alvo   = N'(70);
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
    repeat (2) tick();
    check_eq("abt_pre_estado", 32'(db_estado), 32'd2);
    aborta = 1'b1;
    tick();
    aborta = 1'b0;
    check_eq("abt_db_estado", 32'(db_estado), 32'd0);
    check_quiet("abt", 3 * PER);
    check_eq("abt_pos_hold", 32'(pos), 32'd60);
  endtask
`endif

  initial begin
    zera_s = 1'b1;
    inicia = 1'b0;
    alvo   = '0;
    pos    = '0;
`ifdef CONTROLADOR_ABORTA_EN
    aborta = 1'b0;
`endif
    tick();
    tick();
    check_eq("reset_soma", 32'(soma), 32'd0);
    check_eq("reset_sub", 32'(sub), 32'd0);
    check_eq("reset_pronto", 32'(pronto), 32'd0);
    check_eq("reset_ocupado", 32'(ocupado), 32'd0);
    check_eq("reset_db_estado", 32'(db_estado), 32'd0);
    zera_s = 1'b0;
    tick();

    run_move(10, 13, 1'b0);
    run_move(5, 2, 1'b0);
    run_move(40, 40, 1'b0);
    run_move(90, 120, 1'b0);
    run_move(25, 20, 1'b1);
    reset_mid_move();
`ifdef CONTROLADOR_ABORTA_EN
    abort_mid_move();
`endif
    run_move(0, 0, 1'b0);
    run_move(98, 127, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_move(int'($urandom_range(0, 99)), int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
